// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions raw slide switches for the Nios PIO input.
// Each bit is synchronised with two flops, then its debounced level only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive cycles of
// disagreement. One-cycle rise/fall strobes mark every debounced flip.
// Ports:
//   clk_clk          system clock (shared with the Nios system)
//   reset_reset      asynchronous active-high reset
//   sw_raw           raw switch pins, asynchronous to clk_clk
//   switches_export  debounced levels, wired to the PIO of the same name
//   sw_rise/sw_fall  per-bit one-cycle strobes on debounced 0->1 / 1->0
//   sw_changed       one-cycle strobe when any debounced bit flips
module switch_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches_export,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  // Two-flop synchroniser, no logic between stages.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit stability counter; any agreement restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        rise_d[i]   = sync2_q[i];
        fall_d[i]   = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // Strobes are registered alongside the level so they line up with it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign switches_export = stable_q;
  assign sw_rise         = rise_q;
  assign sw_fall         = fall_q;
  assign sw_changed      = changed_q;

endmodule
